// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the fetch queue: PC width, default section and
//   decode-window sizes, and the section-entry record {data, pc}.
//   No ports.
package fetch_pkg;

  localparam int WIDTH             = 64;
  localparam int DEF_SECTION_BYTES = 16;
  localparam int DEF_WINDOW_BYTES  = 16;

  typedef struct packed {
    logic [8*DEF_SECTION_BYTES-1:0] data;
    logic [WIDTH-1:0]               pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_window_align.sv
// fetch_window_align
//   Combinational byte extractor. Builds the predecode window from the
//   section ring, starting at byte offset `off` within section `head` and
//   continuing seamlessly through following sections (wrapping mod DEPTH).
//   Bytes at or beyond `nvalid` are driven to zero.
// Ports:
//   ring   in  DEPTH sections, section d at bits [d*8*SECTION_BYTES +: 8*SECTION_BYTES]
//   head   in  index of the section holding window byte 0
//   off    in  byte offset of window byte 0 inside the head section
//   nvalid in  number of valid window bytes
//   window out extracted bytes, byte 0 in bits [7:0]
module fetch_window_align #(
  parameter int SECTION_BYTES = 16,
  parameter int DEPTH         = 4,
  parameter int WINDOW_BYTES  = 16,
  parameter int OW            = $clog2(SECTION_BYTES),
  parameter int IW            = $clog2(DEPTH),
  parameter int CW            = $clog2(WINDOW_BYTES) + 1
) (
  input  logic [DEPTH*8*SECTION_BYTES-1:0] ring,
  input  logic [IW-1:0]                    head,
  input  logic [OW-1:0]                    off,
  input  logic [CW-1:0]                    nvalid,
  output logic [8*WINDOW_BYTES-1:0]        window
);

  int sec;
  int pos;

  always_comb begin
    window = '0;
    sec    = 0;
    pos    = 0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (i < int'(nvalid)) begin
        pos = int'(off) + i;
        sec = (int'(head) + pos / SECTION_BYTES) % DEPTH;
        window[8*i +: 8] = ring[8*(sec*SECTION_BYTES + pos % SECTION_BYTES) +: 8];
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Circular multi-section fetch buffer between the fetch engine and
//   predecode. Sections are pushed with a valid/ready handshake, predecode
//   sees a byte window starting at the decode pointer and reports how many
//   bytes it consumed; fully drained sections retire. A redirect flush
//   empties the queue and sets the start offset inside the next section.
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue bypass of the
//   incoming section straight into the window).
// Ports:
//   clk, rst (sync, active-high, honoured only with clkEn), clkEn
//   flush, flushPc                        redirect
//   incomingSection/Pc/Valid, incomingReady  push handshake
//   consumeBytes                          bytes predecode used this cycle
//   windowOut, windowPc, windowBytesValid window to predecode
//   decodePointerOut, preDecodeStall      pointer / too-few-bytes stall
module fetch_queue #(
  parameter int WIDTH         = fetch_pkg::WIDTH,
  parameter int SECTION_BYTES = fetch_pkg::DEF_SECTION_BYTES,
  parameter int DEPTH         = 4,
  parameter int WINDOW_BYTES  = fetch_pkg::DEF_WINDOW_BYTES,
  parameter int MIN_BYTES     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clkEn,
  input  logic                               flush,
  input  logic [WIDTH-1:0]                   flushPc,
  input  logic [8*SECTION_BYTES-1:0]         incomingSection,
  input  logic [WIDTH-1:0]                   incomingPc,
  input  logic                               incomingValid,
  output logic                               incomingReady,
  input  logic [$clog2(WINDOW_BYTES):0]      consumeBytes,
  output logic [8*WINDOW_BYTES-1:0]          windowOut,
  output logic [WIDTH-1:0]                   windowPc,
  output logic [$clog2(WINDOW_BYTES):0]      windowBytesValid,
  output logic [$clog2(SECTION_BYTES)-1:0]   decodePointerOut,
  output logic                               preDecodeStall
);

  import fetch_pkg::*;

  localparam int OW  = $clog2(SECTION_BYTES);
  localparam int IW  = $clog2(DEPTH);
  localparam int OCW = IW + 1;
  localparam int CW  = $clog2(WINDOW_BYTES) + 1;

  function automatic int sat_window(input int n);
    if (n < 0)            return 0;
    if (n > WINDOW_BYTES) return WINDOW_BYTES;
    return n;
  endfunction

  // Consuming more than is shown is illegal; clamp to the visible count.
  function automatic int sat_consume(input int req, input int lim);
    return (req > lim) ? lim : req;
  endfunction

  logic [8*SECTION_BYTES-1:0] data_q [DEPTH];
  logic [WIDTH-1:0]           pc_q   [DEPTH];
  logic [IW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [OCW-1:0]             occ_q, occ_d;
  logic [OW-1:0]              off_q, off_d;
  logic                       push, bypass;
  logic [CW-1:0]              valid_bytes;
  logic [DEPTH*8*SECTION_BYTES-1:0] ring_flat;
  logic                       unused_flush_hi;
  int                         avail, vis, cons, sum;

  assign unused_flush_hi = ^flushPc[WIDTH-1:OW];

  assign incomingReady = (occ_q < OCW'(DEPTH));
  assign push          = clkEn && incomingValid && incomingReady && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (occ_q == '0) && incomingValid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // In bypass the (empty) head slot is replaced by the incoming section so
  // the aligner serves both cases.
  always_comb begin
    ring_flat = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (bypass && head_q == IW'(d))
        ring_flat[d*8*SECTION_BYTES +: 8*SECTION_BYTES] = incomingSection;
      else
        ring_flat[d*8*SECTION_BYTES +: 8*SECTION_BYTES] = data_q[d];
    end
  end

  always_comb begin
    if (bypass) avail = SECTION_BYTES - int'(off_q);
    else        avail = int'(occ_q) * SECTION_BYTES - int'(off_q);
    vis         = sat_window(avail);
    valid_bytes = CW'(vis);
    cons        = sat_consume(int'(consumeBytes), vis);
    sum         = int'(off_q) + cons;

    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    off_d  = off_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      off_d  = flushPc[OW-1:0];
    end else begin
      head_d = head_q + IW'(sum / SECTION_BYTES);
      off_d  = OW'(sum % SECTION_BYTES);
      tail_d = tail_q + IW'(push);
      occ_d  = OCW'(int'(occ_q) + int'(push) - sum / SECTION_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (clkEn) begin
      if (rst) begin
        head_q <= '0;
        tail_q <= '0;
        occ_q  <= '0;
        off_q  <= '0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        occ_q  <= occ_d;
        off_q  <= off_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= incomingSection;
      pc_q[tail_q]   <= incomingPc;
    end
  end

  fetch_window_align #(
    .SECTION_BYTES (SECTION_BYTES),
    .DEPTH         (DEPTH),
    .WINDOW_BYTES  (WINDOW_BYTES)
  ) u_align (
    .ring   (ring_flat),
    .head   (head_q),
    .off    (off_q),
    .nvalid (valid_bytes),
    .window (windowOut)
  );

  // An empty, non-bypassed queue reports PC 0 rather than a stale entry.
  always_comb begin
    if (bypass)             windowPc = incomingPc + WIDTH'(off_q);
    else if (occ_q == '0)   windowPc = '0;
    else                    windowPc = pc_q[head_q] + WIDTH'(off_q);
  end

  assign windowBytesValid = valid_bytes;
  assign decodePointerOut = off_q;
  assign preDecodeStall   = (int'(valid_bytes) < MIN_BYTES);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic         clk = 1'b0;
  logic         rst, clkEn, flush, incomingValid, incomingReady, preDecodeStall;
  logic [63:0]  flushPc, incomingPc, windowPc;
  logic [127:0] incomingSection, windowOut;
  logic [4:0]   consumeBytes, windowBytesValid;
  logic [3:0]   decodePointerOut;

  int checks = 0;
  int errors = 0;

  // Reference model: list of held sections plus the start offset.
  logic [127:0] m_data[$];
  logic [63:0]  m_pc[$];
  int           m_off = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk              (clk),
    .rst              (rst),
    .clkEn            (clkEn),
    .flush            (flush),
    .flushPc          (flushPc),
    .incomingSection  (incomingSection),
    .incomingPc       (incomingPc),
    .incomingValid    (incomingValid),
    .incomingReady    (incomingReady),
    .consumeBytes     (consumeBytes),
    .windowOut        (windowOut),
    .windowPc         (windowPc),
    .windowBytesValid (windowBytesValid),
    .decodePointerOut (decodePointerOut),
    .preDecodeStall   (preDecodeStall)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit m_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (m_data.size() == 0) && incomingValid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Window = byte stream of all held sections, skipping m_off leading bytes.
  task automatic model_window(output logic [127:0] win, output int vb, output logic [63:0] wpc);
    logic [7:0]   stream[$];
    logic [127:0] sec;
    stream = {};
    if (m_bypass()) begin
      sec = incomingSection;
      for (int b = 0; b < 16; b++) stream.push_back(sec[8*b +: 8]);
      wpc = incomingPc + 64'(m_off);
    end else begin
      foreach (m_data[k]) begin
        sec = m_data[k];
        for (int b = 0; b < 16; b++) stream.push_back(sec[8*b +: 8]);
      end
      wpc = (m_data.size() == 0) ? 64'h0 : m_pc[0] + 64'(m_off);
    end
    vb = stream.size() - m_off;
    if (vb < 0)  vb = 0;
    if (vb > 16) vb = 16;
    win = '0;
    for (int i = 0; i < vb; i++) win[8*i +: 8] = stream[m_off + i];
  endtask

  task automatic compare_all();
    logic [127:0] win;
    logic [63:0]  wpc;
    int           vb;
    model_window(win, vb, wpc);
    check("window_bytes_valid", 128'(windowBytesValid), 128'(vb));
    check("window_out", windowOut, win);
    check("window_pc", 128'(windowPc), 128'(wpc));
    check("decode_pointer", 128'(decodePointerOut), 128'(m_off));
    check("stall", 128'(preDecodeStall), 128'(vb < 2));
    check("incoming_ready", 128'(incomingReady), 128'(m_data.size() < 4));
  endtask

  task automatic model_clock();
    logic [127:0] win;
    logic [63:0]  wpc;
    int           vb, c;
    if (!clkEn) return;
    if (rst) begin
      m_data = {}; m_pc = {}; m_off = 0;
    end else if (flush) begin
      m_data = {}; m_pc = {}; m_off = int'(flushPc[3:0]);
    end else begin
      model_window(win, vb, wpc);
      c = (int'(consumeBytes) > vb) ? vb : int'(consumeBytes);
      if (incomingValid && m_data.size() < 4) begin
        m_data.push_back(incomingSection);
        m_pc.push_back(incomingPc);
      end
      m_off += c;
      while (m_off >= 16) begin
        void'(m_data.pop_front());
        void'(m_pc.pop_front());
        m_off -= 16;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; clkEn = 1'b1; flush = 1'b0; incomingValid = 1'b0; consumeBytes = '0;
  endtask

  task automatic offer(input logic [63:0] pc);
    incomingValid = 1'b1; incomingPc = pc; incomingSection = rnd128();
  endtask

  initial begin
    rst = 1'b1; clkEn = 1'b1; flush = 1'b0; flushPc = '0; incomingValid = 1'b0;
    incomingPc = '0; incomingSection = '0; consumeBytes = '0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    check("reset_wbv", 128'(windowBytesValid), 128'd0);
    check("reset_wpc", 128'(windowPc), 128'd0);
    check("reset_window", windowOut, 128'd0);
    check("reset_dp", 128'(decodePointerOut), 128'd0);
    check("reset_stall", 128'(preDecodeStall), 128'd1);
    check("reset_ready", 128'(incomingReady), 128'd1);

    offer(64'h1000); tick();
    check("push1_wpc", 128'(windowPc), 128'h1000);
    check("push1_wbv", 128'(windowBytesValid), 128'd16);
    check("push1_stall", 128'(preDecodeStall), 128'd0);
    offer(64'h1010); tick(); idle();

    consumeBytes = 5'd6; tick();
    check("c6_wpc", 128'(windowPc), 128'h1006);
    consumeBytes = 5'd14; tick(); idle();
    check("c14_wpc", 128'(windowPc), 128'h1014);
    check("c14_dp", 128'(decodePointerOut), 128'd4);
    check("c14_wbv", 128'(windowBytesValid), 128'd12);

    offer(64'h1020); tick();
    offer(64'h1030); tick();
    offer(64'h1040); tick();
    check("full_ready", 128'(incomingReady), 128'd0);
    offer(64'h1050); tick(); tick();
    check("full_held_ready", 128'(incomingReady), 128'd0);
    check("full_held_wpc", 128'(windowPc), 128'h1014);
    consumeBytes = 5'd16; tick(); idle();
    check("retire_ready", 128'(incomingReady), 128'd1);
    check("retire_wpc", 128'(windowPc), 128'h1024);

    consumeBytes = 5'd6; tick();
    check("off10_wpc", 128'(windowPc), 128'h102a);
    offer(64'h1050); consumeBytes = 5'd8; tick(); idle();
    check("wrap_dp", 128'(decodePointerOut), 128'd2);
    check("wrap_wpc", 128'(windowPc), 128'h1032);
    check("wrap_ready", 128'(incomingReady), 128'd1);

    flush = 1'b1; flushPc = 64'h2006; offer(64'h1060); tick(); idle();
    check("flush_wbv", 128'(windowBytesValid), 128'd0);
    check("flush_stall", 128'(preDecodeStall), 128'd1);
    check("flush_dp", 128'(decodePointerOut), 128'd6);
    offer(64'h2000); tick(); idle();
    check("redirect_wpc", 128'(windowPc), 128'h2006);
    check("redirect_wbv", 128'(windowBytesValid), 128'd10);

    clkEn = 1'b0; rst = 1'b1; flush = 1'b1; flushPc = 64'h40;
    offer(64'h3000); consumeBytes = 5'd4;
    repeat (3) tick();
    idle();
    check("hold_wpc", 128'(windowPc), 128'h2006);
    check("hold_wbv", 128'(windowBytesValid), 128'd10);
    check("hold_dp", 128'(decodePointerOut), 128'd6);

    for (int n = 0; n < 600; n++) begin
      clkEn           = ($urandom_range(0, 9) != 0);
      rst             = ($urandom_range(0, 99) == 0);
      flush           = ($urandom_range(0, 29) == 0);
      flushPc         = {$urandom, $urandom};
      incomingValid   = ($urandom_range(0, 2) != 0);
      incomingPc      = {$urandom, $urandom} & ~64'hF;
      incomingSection = rnd128();
      consumeBytes    = 5'($urandom_range(0, 16));
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
